// File: rtl/jtag_uart_sys_xmit_byte.sv
// rtl/jtag_uart_sys_xmit_byte.sv - inbound user-to-CPU word FIFO behind an Avalon-MM s1 slave
//
// Optional feature macro: XMIT_BYTE_IRQ_EN
//   defined   : IRQMSK register implemented, registered level interrupt
//   undefined : IRQMSK reads 0 / ignores writes, irq tied low
module jtag_uart_sys_xmit_byte #(
  parameter int DATA_W = 9,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              irq
);

  // Pointer and fill-level widths follow from DEPTH; level needs one extra bit
  // so that a completely full FIFO (level == DEPTH) is representable.
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_IRQMSK = 2'd2;
  localparam logic [1:0] ADDR_FLUSH  = 2'd3;

  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q,  level_d;
  logic              ovf_q,    ovf_d;
  // Goes high on the first clock edge after reset is released; holds in_ready
  // low for the whole reset interval without a combinational path from reset.
  logic              alive_q;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic empty;
  logic full;
  logic wr_en;
  logic rd_data_strobe;
  logic flush;
  logic ovf_clr;
  logic push;
  logic pop;
  logic drop;

  assign empty          = (level_q == '0);
  assign full           = (level_q == LVL_FULL);
  assign wr_en          = chipselect & ~write_n;
  assign rd_data_strobe = chipselect & read & (address == ADDR_DATA);
  assign flush          = wr_en & (address == ADDR_FLUSH);
  assign ovf_clr        = wr_en & (address == ADDR_STATUS) & writedata[2];

  assign in_ready = alive_q & ~full;

  // A flush discards anything arriving or leaving in the same cycle.
  assign push = in_valid & in_ready & ~flush;
  // A DATA read on an empty FIFO reports valid=0 and must not move pointers.
  assign pop  = rd_data_strobe & ~empty & ~flush;
  // Words presented while full are lost; overflow records that it happened.
  assign drop = in_valid & full;

  // ---------------------------------------------------------------------------
  // Next-state: pointers, level and sticky overflow
  // ---------------------------------------------------------------------------
  // Compute FIFO bookkeeping for the coming edge; flush overrides push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      unique case ({push, pop})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end

    // Clear first so that a same-cycle drop leaves overflow set.
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  // Register FIFO bookkeeping; asynchronous reset returns to the empty state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      alive_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      alive_q  <= 1'b1;
    end
  end

  // Storage array; contents need no reset because level gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional interrupt mask and interrupt output
  // ---------------------------------------------------------------------------
  logic [1:0] msk_rd;

`ifdef XMIT_BYTE_IRQ_EN
  logic [1:0] msk_q, msk_d;
  logic       irq_q, irq_d;

  // Mask register update and interrupt condition from registered state.
  always_comb begin
    msk_d = msk_q;
    if (wr_en && (address == ADDR_IRQMSK)) begin
      msk_d = writedata[1:0];
    end
    irq_d = (msk_q[0] & ~empty) | (msk_q[1] & ovf_q);
  end

  // Registered mask and interrupt; irq lags its cause by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msk_q <= '0;
      irq_q <= 1'b0;
    end else begin
      msk_q <= msk_d;
      irq_q <= irq_d;
    end
  end

  assign msk_rd = msk_q;
  assign irq    = irq_q;

  logic unused_wdata;
  assign unused_wdata = ^writedata[31:3];
`else
  assign msk_rd = 2'b00;
  assign irq    = 1'b0;

  logic unused_wdata;
  assign unused_wdata = ^{writedata[31:3], writedata[1:0]};
`endif

  // ---------------------------------------------------------------------------
  // s1 read mux (zero wait states, purely combinational)
  // ---------------------------------------------------------------------------
  logic [8:0]  head_field;
  logic [15:0] level_w16;
  logic [7:0]  level_w8;

  // The head word field reads 0 when empty so an empty read is fully defined.
  assign head_field = empty ? 9'd0 : 9'(mem_q[rd_ptr_q]);
  assign level_w16  = 16'(level_q);
  assign level_w8   = 8'(level_q);

  // Select the register image for the current address.
  always_comb begin
    readdata = '0;
    unique case (address)
      ADDR_DATA:   readdata = {level_w16, 6'd0, ~empty, head_field};
      ADDR_STATUS: readdata = {16'd0, level_w8, 5'd0, ovf_q, full, empty};
      ADDR_IRQMSK: readdata = {30'd0, msk_rd};
      ADDR_FLUSH:  readdata = '0;
      default:     readdata = '0;
    endcase
  end

endmodule
